vedic_mul16_seq_ctrl: RTL and testbench
=======================================

// Module: vedic_mul16_seq_ctrl
// PURPOSE
//  Sequential 16x16 unsigned multiplier controller built around one shared
//  combinational Vedic_8B (8x8 -> 16) core. Splits each operand into high and
//  low bytes and drives the four 8x8 partial products through the core, one
//  per cycle (Urdhva-Tiryagbhyam order). Shifts and accumulates the partial
//  products into a 32-bit result. Valid/ready handshakes sit on the input and
//  output sides, so the block drops into any streaming datapath.
// PARAMETERS
//  PP_REG   0   1 = register the Vedic_8B output before accumulating (+1 cycle latency)
//  OP_W     16  operand width; only 16 is supported (elaboration error otherwise)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   block can accept operands
//  a          in   16  multiplicand, unsigned
//  b          in   16  multiplier, unsigned
//  out_valid  out  1   p holds a finished product
//  out_ready  in   1   downstream accepts p
//  p          out  32  product a*b, unsigned
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE, step counter=0, operand regs=0, acc=0.
//    - p=0, out_valid=0, in_ready=0 while in reset; in_ready=1 from the first
//      clock after release. busy=0.
//  - FSM states: IDLE -> MUL -> [FILL if PP_REG] -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On the edge where in_valid & in_ready: latch a and b, clear acc,
//      set step=0, go to MUL.
//    - Operands are sampled only on this edge; later changes on a/b are ignored.
//  - MUL (4 cycles, step 0..3): core inputs per step, with accumulate shift:
//    - step 0: aL*bL, shift 0
//    - step 1: aL*bH, shift 8
//    - step 2: aH*bL, shift 8
//    - step 3: aH*bH, shift 16
//  - Accumulate: acc <= acc + ({16'b0,pp} << shift).
//    - The 32-bit acc cannot overflow; the maximum is 0xFFFE0001.
//    - PP_REG=0: accumulate on the same edge as the step.
//    - PP_REG=1: accumulate one edge later. FILL is a single cycle that
//      absorbs the last registered partial product.
//  - After the final accumulate edge go to DONE. p=acc, out_valid=1.
//  - Latency: out_valid rises on accept edge + 4 edges (PP_REG=0), or
//    + 5 edges (PP_REG=1).
//  - DONE:
//    - p and out_valid are held stable while out_ready=0, for an unbounded time.
//    - On the edge with out_valid & out_ready, go to IDLE and drop out_valid.
//    - p keeps its last value.
//    - in_ready stays 0 in DONE, so there is no simultaneous accept and
//      retire. Throughput is one product per 6 cycles (7 with PP_REG=1),
//      given continuous in_valid and out_ready.
//  - in_ready=0 in MUL, FILL and DONE; in_valid there is ignored and not queued.
//  - Reset mid-operation: the operation is aborted, the partial acc is
//    discarded, and no out_valid is produced.
//  - Illegal state encodings recover to IDLE on the next edge.
// STRUCTURE
//  - Shared package vedic_mul_pkg:
//    - state encodings (IDLE, MUL, FILL, DONE)
//    - NUM_PP=4
//    - per-step shift table {0,8,8,16}
//    - per-step operand-byte select table
//  - Sub-module: one instance of the existing Vedic_8B (a[7:0], b[7:0] -> c[15:0]),
//    used unchanged.
//  - All control, muxing and the accumulator live in this module.
// TESTING
//  1. a=0xFFFF, b=0xFFFF, out_ready=1
//     -> p=0xFFFE0001; out_valid exactly 4 edges after accept (PP_REG=0).
//  2. a=0x0099, b=0x002F -> p=0x00001C17 (153*47).
//     Then a=0x1234, b=0x5678 back-to-back -> p=0x06260060.
//  3. Backpressure: hold out_ready=0 for 3 cycles after out_valid
//     -> p and out_valid stable, in_ready=0 throughout.
//     Release -> exactly one transfer.
//  4. Reset mid-op: rst_n=0 at step 2 of a=0xABCD, b=0x1111
//     -> p=0 and out_valid=0 immediately.
//     The next operation, a=0x0000, b=0xABCD, returns p=0.
//  5. Input churn: change a/b and pulse in_valid during MUL
//     -> result equals the product of the originally accepted operands.
//  6. PP_REG=1 build: repeat 1 and 2 -> same products, latency 5 edges,
//     FILL observed.

Source files
------------

// File: rtl/vedic_mul_pkg.sv
// Shared definitions for the sequential 16x16 Vedic multiplier controller:
// FSM state encoding, partial-product count and the per-step tables that
// pick operand bytes and accumulate shifts.
package vedic_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned NUM_PP = 4;

    // Accumulate shift per step, step 0 in the low field: {16, 8, 8, 0}.
    localparam logic [19:0] PP_SHIFT_TAB = {5'd16, 5'd8, 5'd8, 5'd0};

    // Bit n set = step n uses the high byte of that operand.
    // Steps: aL*bL, aL*bH, aH*bL, aH*bH.
    localparam logic [3:0] SEL_A_HI = 4'b1100;
    localparam logic [3:0] SEL_B_HI = 4'b1010;

    function automatic logic [4:0] pp_shift(input logic [1:0] step);
        return PP_SHIFT_TAB[5*step +: 5];
    endfunction

endpackage

// File: rtl/Vedic_8B.sv
// Combinational 8x8 -> 16 unsigned Vedic multiplier. The operands are split
// into nibbles, the four 4x4 cross products are formed, and the products are
// summed at their nibble weights.
module Vedic_8B (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] c
);

    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [7:0] q3;

    assign q0 = {4'b0, a[3:0]} * {4'b0, b[3:0]};
    assign q1 = {4'b0, a[3:0]} * {4'b0, b[7:4]};
    assign q2 = {4'b0, a[7:4]} * {4'b0, b[3:0]};
    assign q3 = {4'b0, a[7:4]} * {4'b0, b[7:4]};

    assign c = {q3, 8'b0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {8'b0, q0};

endmodule

// File: rtl/vedic_mul16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier. One shared Vedic_8B core produces the
// four byte partial products over four cycles; they are shifted and summed
// into a 32-bit accumulator. Valid/ready handshakes on both sides, no overlap
// between retiring a product and accepting the next operand pair.
module vedic_mul16_seq_ctrl
    import vedic_mul_pkg::*;
#(
    parameter int unsigned PP_REG = 0,
    parameter int unsigned OP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] p,
    output logic              busy
);

    if (OP_W != 16) begin : g_bad_width
        $error("vedic_mul16_seq_ctrl: OP_W must be 16");
    end

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  step_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] acc_q;
    logic [31:0] p_q;
    logic        ready_en_q;

    logic        accept;
    logic        last_step;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic [15:0] pp;
    logic [31:0] addend;
    logic [31:0] acc_sum;
    logic        acc_en;
    logic        final_edge;

    assign accept    = in_valid & in_ready;
    assign last_step = (state_q == ST_MUL) && (step_q == 2'(NUM_PP - 1));

    assign core_a = SEL_A_HI[step_q] ? a_q[15:8] : a_q[7:0];
    assign core_b = SEL_B_HI[step_q] ? b_q[15:8] : b_q[7:0];

    Vedic_8B u_core (
        .a (core_a),
        .b (core_b),
        .c (pp)
    );

    if (PP_REG != 0) begin : g_pp_reg
        logic [15:0] pp_q;
        logic [4:0]  pp_shift_q;
        logic        pp_vld_q;

        // Partial product pipeline stage: every MUL cycle registers the core
        // output and its shift; the accumulate then trails by one edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pp_q       <= '0;
                pp_shift_q <= '0;
                pp_vld_q   <= 1'b0;
            end else begin
                pp_q       <= pp;
                pp_shift_q <= pp_shift(step_q);
                pp_vld_q   <= (state_q == ST_MUL);
            end
        end

        assign addend     = {16'b0, pp_q} << pp_shift_q;
        assign acc_en     = pp_vld_q;
        assign final_edge = (state_q == ST_FILL);
    end else begin : g_pp_direct
        assign addend     = {16'b0, pp} << pp_shift(step_q);
        assign acc_en     = (state_q == ST_MUL);
        assign final_edge = last_step;
    end

    assign acc_sum = acc_q + addend;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = ready_en_q;
                busy     = 1'b0;
                if (accept) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (last_step) begin
                    state_d = (PP_REG != 0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture, step counter, accumulator and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            step_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            p_q        <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                acc_q  <= '0;
                step_q <= '0;
            end else begin
                if (state_q == ST_MUL) begin
                    step_q <= step_q + 2'd1;
                end
                if (acc_en) begin
                    acc_q <= acc_sum;
                end
                if (final_edge) begin
                    p_q <= acc_sum;
                end
            end
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_vedic_mul16_seq_ctrl.sv
// Bench for vedic_mul16_seq_ctrl: drives a PP_REG=0 and a PP_REG=1 instance
// with the same directed operand pairs, compares both against a latency/
// product model every cycle, and pins products and latencies to literals.
module tb_vedic_mul16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        ir[2];
    logic        ov[2];
    logic        bz[2];
    logic [31:0] pv[2];

    int errors = 0;
    int checks = 0;

    localparam int LAT[2] = '{4, 5};

    always #5 clk = ~clk;

    vedic_mul16_seq_ctrl #(.PP_REG(0), .OP_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .p(pv[0]), .busy(bz[0])
    );

    vedic_mul16_seq_ctrl #(.PP_REG(1), .OP_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .p(pv[1]), .busy(bz[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Model: phase 0 = idle, 1 = computing, 2 = holding a result.
    int          m_phase[2];
    int          m_cnt[2];
    logic [31:0] m_prod[2];
    logic [31:0] m_p[2];
    bit          m_rdy;
    int          xfers[2] = '{0, 0};
    logic [31:0] got_p[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                m_phase[l] = 0;
                m_cnt[l]   = 0;
                m_p[l]     = '0;
            end
            m_rdy = 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (ov[l] && out_ready) begin
                    xfers[l]++;
                    got_p[l] = pv[l];
                end
                case (m_phase[l])
                    0: if (m_rdy && in_valid) begin
                        m_prod[l]  = {16'b0, a} * {16'b0, b};
                        m_cnt[l]   = LAT[l];
                        m_phase[l] = 1;
                    end
                    1: begin
                        m_cnt[l]--;
                        if (m_cnt[l] == 0) begin
                            m_phase[l] = 2;
                            m_p[l]     = m_prod[l];
                        end
                    end
                    default: if (out_ready) m_phase[l] = 0;
                endcase
            end
            m_rdy = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("lane%0d in_ready", l), 32'(ir[l]), 32'(m_rdy && m_phase[l] == 0));
            chk($sformatf("lane%0d out_valid", l), 32'(ov[l]), 32'(m_phase[l] == 2));
            chk($sformatf("lane%0d busy", l), 32'(bz[l]), 32'(m_phase[l] != 0));
            chk($sformatf("lane%0d p", l), pv[l], m_p[l]);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(ir[0] && ir[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(ir[0] && ir[1])) begin
            errors++;
            checks++;
            $display("FAIL wait_idle: in_ready not seen within 50 cycles");
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input int hold,
                          input logic [31:0] exp_p, input bit churn);
        int lat[2];
        int x0[2];
        wait_idle();
        x0 = xfers;
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (churn) begin
            a = 16'hFFFF;
            b = 16'hFFFF;
            in_valid = 1'b1;
        end
        lat = '{0, 0};
        for (int k = 1; k <= 20; k++) begin
            if (lat[0] != 0 && lat[1] != 0) break;
            @(posedge clk);
            #1;
            if (churn && k == 2) in_valid = 1'b0;
            for (int l = 0; l < 2; l++)
                if (ov[l] && lat[l] == 0) lat[l] = k;
        end
        chk("latency lane0", 32'(lat[0]), 32'd4);
        chk("latency lane1", 32'(lat[1]), 32'd5);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                for (int l = 0; l < 2; l++) begin
                    chk($sformatf("hold lane%0d out_valid", l), 32'(ov[l]), 32'd1);
                    chk($sformatf("hold lane%0d in_ready", l), 32'(ir[l]), 32'd0);
                    chk($sformatf("hold lane%0d p", l), pv[l], exp_p);
                end
            end
            out_ready = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("xfer count lane%0d", l), 32'(xfers[l] - x0[l]), 32'd1);
            chk($sformatf("product lane%0d", l), got_p[l], exp_p);
        end
        chk("model product", m_p[0], exp_p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset in_ready", 32'(ir[0]), 32'd0);
        chk("reset out_valid", 32'(ov[0]), 32'd0);
        chk("reset busy", 32'(bz[0]), 32'd0);
        chk("reset p", pv[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after release", 32'(ir[0]), 32'd1);

        run_op(16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 1'b0);
        run_op(16'h0099, 16'h002F, 0, 32'h00001C17, 1'b0);
        run_op(16'h1234, 16'h5678, 0, 32'h06260060, 1'b0);
        run_op(16'h0F0F, 16'h00F0, 3, 32'h000E1E10, 1'b0);

        begin : reset_mid_op
            int x0[2];
            wait_idle();
            a = 16'hABCD;
            b = 16'h1111;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            x0 = xfers;
            rst_n = 1'b0;
            #1;
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("mid-reset lane%0d p", l), pv[l], 32'd0);
                chk($sformatf("mid-reset lane%0d out_valid", l), 32'(ov[l]), 32'd0);
                chk($sformatf("mid-reset lane%0d in_ready", l), 32'(ir[l]), 32'd0);
            end
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (8) @(negedge clk);
            for (int l = 0; l < 2; l++)
                chk($sformatf("mid-reset lane%0d no xfer", l), 32'(xfers[l] - x0[l]), 32'd0);
        end

        run_op(16'h0000, 16'hABCD, 0, 32'h00000000, 1'b0);
        run_op(16'h00FF, 16'h0101, 0, 32'h0000FFFF, 1'b1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
